// File: rtl/mul_arbiter.sv
// Round-robin front end for a shared fixed-latency 32x32 multiplier.
// Credit-gated issue guarantees every result lands in a free per-requester FIFO slot.
module mul_arbiter #(
    parameter int LAT   = 2,
    parameter int DEPTH = 2
) (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_signed,
    input  logic [31:0] a_x,
    input  logic [31:0] a_y,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_signed,
    input  logic [31:0] b_x,
    input  logic [31:0] b_y,
    output logic        m_valid,
    output logic        m_signed,
    output logic [31:0] m_x,
    output logic [31:0] m_y,
    input  logic [63:0] m_result,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    output logic [63:0] a_rsp_result,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [63:0] b_rsp_result
);

    localparam int            CW      = 4;
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PONE    = PW'(1);

    // Index 0 is requester A, index 1 is requester B throughout.
    logic [CW-1:0]  infl_q [2];
    logic [CW-1:0]  infl_d [2];
    logic [CW-1:0]  cnt_q  [2];
    logic [CW-1:0]  cnt_d  [2];
    logic [PW-1:0]  wr_q   [2];
    logic [PW-1:0]  wr_d   [2];
    logic [PW-1:0]  rd_q   [2];
    logic [PW-1:0]  rd_d   [2];
    logic [63:0]    mem_q  [2][DEPTH];
    logic [LAT-1:0] tv_q;
    logic [LAT-1:0] tid_q;
    logic           last_q;
    logic           last_d;
    logic [1:0]     vld;
    logic [1:0]     elig;
    logic [1:0]     req;
    logic [1:0]     gnt;
    logic [1:0]     cap;
    logic [1:0]     pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PONE;
    endfunction

    always_comb begin
        vld    = '0;
        elig   = '0;
        gnt    = '0;
        cap    = '0;
        infl_d = infl_q;
        cnt_d  = cnt_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        for (int i = 0; i < 2; i++) begin
            vld[i]  = (cnt_q[i] != '0);
            elig[i] = (infl_q[i] + cnt_q[i]) < DEPTH_C;
        end
        // Grants are held off while reset is asserted so ready/m_valid read 0.
        req    = {b_valid, a_valid} & elig & {2{resetn}};
        gnt[0] = req[0] & (~req[1] | last_q);
        gnt[1] = req[1] & (~req[0] | ~last_q);
        cap[0] = tv_q[LAT-1] & ~tid_q[LAT-1];
        cap[1] = tv_q[LAT-1] & tid_q[LAT-1];
        pop    = vld & {b_rsp_ready, a_rsp_ready};
        last_d = (|gnt) ? gnt[1] : last_q;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i] && !cap[i])
                infl_d[i] = infl_q[i] + ONE;
            else if (!gnt[i] && cap[i])
                infl_d[i] = infl_q[i] - ONE;
            if (cap[i] && !pop[i])
                cnt_d[i] = cnt_q[i] + ONE;
            else if (!cap[i] && pop[i])
                cnt_d[i] = cnt_q[i] - ONE;
            if (cap[i])
                wr_d[i] = ptr_inc(wr_q[i]);
            if (pop[i])
                rd_d[i] = ptr_inc(rd_q[i]);
        end
    end

    assign a_ready      = gnt[0];
    assign b_ready      = gnt[1];
    assign m_valid      = |gnt;
    assign m_signed     = (gnt[0] & a_signed) | (gnt[1] & b_signed);
    assign m_x          = ({32{gnt[0]}} & a_x) | ({32{gnt[1]}} & b_x);
    assign m_y          = ({32{gnt[0]}} & a_y) | ({32{gnt[1]}} & b_y);
    assign a_rsp_valid  = vld[0];
    assign b_rsp_valid  = vld[1];
    assign a_rsp_result = vld[0] ? mem_q[0][rd_q[0]] : '0;
    assign b_rsp_result = vld[1] ? mem_q[1][rd_q[1]] : '0;

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            tv_q   <= '0;
            tid_q  <= '0;
            last_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                infl_q[i] <= '0;
                cnt_q[i]  <= '0;
                wr_q[i]   <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            tv_q[0]  <= |gnt;
            tid_q[0] <= gnt[1];
            for (int s = 1; s < LAT; s++) begin
                tv_q[s]  <= tv_q[s-1];
                tid_q[s] <= tid_q[s-1];
            end
            last_q <= last_d;
            for (int i = 0; i < 2; i++) begin
                infl_q[i] <= infl_d[i];
                cnt_q[i]  <= cnt_d[i];
                wr_q[i]   <= wr_d[i];
                rd_q[i]   <= rd_d[i];
            end
        end
    end

    // Storage needs no reset: the head is only exposed while the count is non-zero.
    always_ff @(posedge mul_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cap[i])
                mem_q[i][wr_q[i]] <= m_result;
        end
    end

    a_no_overflow_a : assert property (@(posedge mul_clk) disable iff (!resetn)
        cap[0] |-> (cnt_q[0] < DEPTH_C));
    a_no_overflow_b : assert property (@(posedge mul_clk) disable iff (!resetn)
        cap[1] |-> (cnt_q[1] < DEPTH_C));

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: a behavioural multiplier feeds results back,
// expected products are queued at grant time and checked as responses pop.
module tb_mul_arbiter;

    localparam int LAT   = 2;
    localparam int DEPTH = 2;

    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        a_valid, a_ready, a_signed;
    logic [31:0] a_x, a_y;
    logic        b_valid, b_ready, b_signed;
    logic [31:0] b_x, b_y;
    logic        m_valid, m_signed;
    logic [31:0] m_x, m_y;
    logic [63:0] m_result;
    logic        a_rsp_valid, a_rsp_ready;
    logic [63:0] a_rsp_result;
    logic        b_rsp_valid, b_rsp_ready;
    logic [63:0] b_rsp_result;

    mul_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .mul_clk     (mul_clk),
        .resetn      (resetn),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_signed    (a_signed),
        .a_x         (a_x),
        .a_y         (a_y),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_signed    (b_signed),
        .b_x         (b_x),
        .b_y         (b_y),
        .m_valid     (m_valid),
        .m_signed    (m_signed),
        .m_x         (m_x),
        .m_y         (m_y),
        .m_result    (m_result),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_result(a_rsp_result),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_result(b_rsp_result)
    );

    always #5 mul_clk = ~mul_clk;

    // Hand-computed vectors: x, y, signed, expected 64-bit product.
    logic [31:0] VX [16] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000,
                             32'h80000000, 32'h80000000, 32'h0000000C, 32'h7FFFFFFF,
                             32'h2, 32'h4, 32'h6, 32'h8, 32'hA, 32'hFFFFFFFE, 32'h100, 32'hFFFFFFFE};
    logic [31:0] VY [16] = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000,
                             32'h2, 32'h2, 32'hD, 32'hFFFFFFFF,
                             32'h3, 32'h5, 32'h7, 32'h9, 32'hB, 32'h2, 32'h100, 32'h2};
    logic        VS [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] VE [16] = '{64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFE00000001, 64'h1, 64'h100000000,
                             64'hFFFFFFFF00000000, 64'h100000000, 64'h9C, 64'hFFFFFFFF80000001,
                             64'h6, 64'h14, 64'h2A, 64'h48, 64'h6E, 64'hFFFFFFFFFFFFFFFC,
                             64'h10000, 64'h1FFFFFFFC};

    function automatic logic [63:0] mref(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [32:0] sx, sy;
        logic signed [65:0] p;
        sx = {s & x[31], x};
        sy = {s & y[31], y};
        p  = 66'(sx) * 66'(sy);
        return p[63:0];
    endfunction

    // Behavioural fixed-latency multiplier.
    logic [63:0] mp [LAT];
    always @(posedge mul_clk) begin
        mp[0] <= mref(m_x, m_y, m_signed);
        for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
    end
    assign m_result = mp[LAT-1];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_a, exp_b;
    logic [63:0] qa [$];
    logic [63:0] qb [$];
    bit          gseq [$];
    logic        sg_a, sg_b;
    int          ia, ib;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: compares popped responses, queues expectations on grants.
    always @(negedge mul_clk) begin
        logic [63:0] ev;
        if (resetn) begin
            if (a_rsp_valid && a_rsp_ready) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_a: got %h with no result outstanding", a_rsp_result);
                end else begin
                    ev = qa.pop_front();
                    if (a_rsp_result !== ev) begin
                        n_bad++;
                        $display("FAIL rsp_a: got %h expected %h", a_rsp_result, ev);
                    end
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_b: got %h with no result outstanding", b_rsp_result);
                end else begin
                    ev = qb.pop_front();
                    if (b_rsp_result !== ev) begin
                        n_bad++;
                        $display("FAIL rsp_b: got %h expected %h", b_rsp_result, ev);
                    end
                end
            end
            if (a_valid && a_ready) qa.push_back(exp_a);
            if (b_valid && b_ready) qb.push_back(exp_b);
            if (m_valid) gseq.push_back(b_ready);
            n_cmp++;
            if ((m_valid !== (a_ready | b_ready)) || (a_ready && b_ready)) begin
                n_bad++;
                $display("FAIL grant_excl: a_ready=%b b_ready=%b m_valid=%b", a_ready, b_ready, m_valid);
            end
        end
    end

    task automatic load_a(input int idx);
        ia = idx; a_x = VX[idx % 16]; a_y = VY[idx % 16]; a_signed = VS[idx % 16]; exp_a = VE[idx % 16];
    endtask

    task automatic load_b(input int idx);
        ib = idx; b_x = VX[idx % 16]; b_y = VY[idx % 16]; b_signed = VS[idx % 16]; exp_b = VE[idx % 16];
    endtask

    // One cycle: sample grants mid-cycle, advance granted operands after the edge.
    task automatic step();
        @(negedge mul_clk);
        sg_a = a_ready;
        sg_b = b_ready;
        @(posedge mul_clk);
        #1;
        if (sg_a) load_a(ia + 1);
        if (sg_b) load_b(ib + 1);
    endtask

    task automatic send_a(input int idx);
        bit got = 0;
        load_a(idx);
        a_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (sg_a) begin got = 1; break; end
        end
        a_valid = 1'b0;
        check("send_a_granted", {63'd0, got}, 64'd1);
    endtask

    task automatic send_b(input int idx);
        bit got = 0;
        load_b(idx);
        b_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (sg_b) begin got = 1; break; end
        end
        b_valid = 1'b0;
        check("send_b_granted", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_drain(input string nm);
        bit ok = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge mul_clk);
            #1;
            if (qa.size() == 0 && qb.size() == 0 && !a_rsp_valid && !b_rsp_valid) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_drain: %0d/%0d results still outstanding", nm, qa.size(), qb.size());
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge mul_clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  na, nb, stale;
        logic [7:0] pat;

        resetn = 1'b0;
        a_valid = 1'b1; b_valid = 1'b0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        load_a(0); load_b(0);
        #2;
        check("rst_ready_valid", {60'd0, a_ready, b_ready, m_valid, 1'b0}, 64'd0);
        check("rst_rsp_valid", {62'd0, a_rsp_valid, b_rsp_valid}, 64'd0);
        check("rst_m_bus", {m_x, m_y} | {63'd0, m_signed}, 64'd0);
        check("rst_rsp_result", a_rsp_result | b_rsp_result, 64'd0);
        a_valid = 1'b0;
        @(posedge mul_clk);
        #1;
        resetn = 1'b1;

        // Single signed op with exact latency.
        send_a(0);
        repeat (LAT) @(negedge mul_clk);
        check("lat_not_early", {63'd0, a_rsp_valid}, 64'd0);
        @(negedge mul_clk);
        check("lat_on_time", {63'd0, a_rsp_valid}, 64'd1);
        check("no_b_rsp", {63'd0, b_rsp_valid}, 64'd0);
        wait_drain("single");

        // Unsigned then signed all-ones.
        send_b(1);
        wait_drain("b_unsigned");
        send_b(2);
        wait_drain("b_signed");

        // Contention right after reset: A first, then strict alternation.
        do_reset();
        gseq.delete();
        load_a(8); load_b(12);
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (8) step();
        a_valid = 1'b0; b_valid = 1'b0;
        pat = '0;
        for (int i = 0; i < 8 && i < gseq.size(); i++) pat[i] = gseq[i];
        check("contend_grants", 64'(gseq.size()), 64'd8);
        check("contend_order", {56'd0, pat}, 64'hAA);
        wait_drain("contend");

        // Back-pressure on A, B keeps flowing.
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b1;
        load_a(3); load_b(0);
        a_valid = 1'b1; b_valid = 1'b1;
        na = 0; nb = 0;
        repeat (12) begin
            step();
            na += int'(sg_a);
            nb += int'(sg_b);
        end
        check("bp_a_grants", 64'(na), 64'(DEPTH));
        check("bp_b_flowing", {63'd0, nb >= 4}, 64'd1);
        b_valid = 1'b0;
        a_rsp_ready = 1'b1;
        step();
        check("bp_pop_cycle_no_grant", {63'd0, sg_a}, 64'd0);
        step();
        check("bp_grant_after_pop", {63'd0, sg_a}, 64'd1);
        repeat (4) step();
        a_valid = 1'b0;
        wait_drain("backpressure");

        // Reset with two A ops in flight.
        load_a(4);
        a_valid = 1'b1;
        step();
        step();
        a_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_ctrl", {59'd0, a_ready, b_ready, m_valid, a_rsp_valid, b_rsp_valid}, 64'd0);
        check("midrst_data", {m_x, m_y} | a_rsp_result | b_rsp_result, 64'd0);
        qa.delete();
        qb.delete();
        repeat (2) @(posedge mul_clk);
        #1;
        resetn = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge mul_clk);
            if (a_rsp_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'd0);
        send_a(6);
        wait_drain("after_reset");

        // Random soak against the reference product.
        for (int c = 0; c < 1500; c++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_signed = 1'($urandom_range(0, 1));
            b_signed = 1'($urandom_range(0, 1));
            a_x = $urandom; a_y = $urandom; b_x = $urandom; b_y = $urandom;
            exp_a = mref(a_x, a_y, a_signed);
            exp_b = mref(b_x, b_y, b_signed);
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            b_rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge mul_clk);
            #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        wait_drain("soak");
        check("final_qa_empty", 64'(qa.size()), 64'd0);
        check("final_qb_empty", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
